// File: rtl/dac_da2_tx.sv
// dac_da2_tx: two-lane SYNC-framed serial transmitter for the Pmod DA2
// (dual DAC121S101). Loads one 12-bit code per lane on a start strobe. It
// shifts both 16-bit words out MSB first on a divided SCLK.
// Optional feature: define DAC_TX_PENDING_EN to add a one-entry pending slot.
// With the slot, a strobe that arrives mid-frame is sent back to back. Without
// the slot, that strobe is dropped and flagged on overrun.
module dac_da2_tx #(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic        CLOCK,
  input  logic        RESETN,
  input  logic        start,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        dac_sync,
  output logic        dac_sclk,
  output logic        dac_dina,
  output logic        dac_dinb
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [7:0] HMAX = 8'(SCLK_DIV);

  logic [2:0]  state_q, state_d;
  logic [7:0]  hcnt_q, hcnt_d;    // clock count inside the current half-period
  logic [5:0]  hp_q, hp_d;        // half-periods elapsed since frame start (0..34)
  logic [15:0] sha_q, sha_d;
  logic [15:0] shb_q, shb_d;
  logic        sync_q, sync_d;
  logic        sclk_q, sclk_d;
  logic        dina_q, dina_d;
  logic        dinb_q, dinb_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

`ifdef DAC_TX_PENDING_EN
  logic        pvld_q, pvld_d;
  logic [11:0] pa_q, pa_d;
  logic [11:0] pb_q, pb_d;
`endif

  logic        tick;
  logic [5:0]  hp_nx;
  logic        frame_end;
  logic        launch;
  logic [15:0] word_a;
  logic [15:0] word_b;

  assign tick      = (hcnt_q == HMAX);
  assign hp_nx     = hp_q + 6'd1;
  assign frame_end = (state_q == ST_GAP) && tick && (hp_q == 6'd34);

  // Next-state: half-period boundaries drive SCLK, data, SYNC and the FSM.
  // A launch (new E0) overrides everything else.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    hp_d    = hp_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    sync_d  = sync_q;
    sclk_d  = sclk_q;
    dina_d  = dina_q;
    dinb_d  = dinb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    launch  = 1'b0;
    word_a  = {4'b0000, sample_a};
    word_b  = {4'b0000, sample_b};
`ifdef DAC_TX_PENDING_EN
    pvld_d  = pvld_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
`endif

    if (state_q != ST_IDLE) begin
      hcnt_d = tick ? 8'd0 : hcnt_q + 8'd1;
      if (tick) begin
        hp_d = hp_nx;
        if (hp_nx <= 6'd31) begin
          if (hp_nx[0]) begin
            // Falling SCLK: the DAC samples here, so data is left alone.
            sclk_d = 1'b0;
            if (hp_nx == 6'd1) state_d = ST_SHIFT;
          end else begin
            // Rising SCLK: advance to the next bit.
            sclk_d = 1'b1;
            dina_d = sha_q[14];
            dinb_d = shb_q[14];
            sha_d  = {sha_q[14:0], 1'b0};
            shb_d  = {shb_q[14:0], 1'b0};
          end
        end else if (hp_nx == 6'd32) begin
          sclk_d  = 1'b1;
          dina_d  = 1'b0;
          dinb_d  = 1'b0;
          state_d = ST_HOLD;
        end else if (hp_nx == 6'd33) begin
          sync_d  = 1'b1;
          state_d = ST_GAP;
        end else if (hp_nx == 6'd35) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    end

`ifdef DAC_TX_PENDING_EN
    // Slot drains first at GAP exit, so a coincident strobe refills it
    // without counting as an overwrite.
    if (frame_end && pvld_q) begin
      launch = 1'b1;
      word_a = {4'b0000, pa_q};
      word_b = {4'b0000, pb_q};
      pvld_d = 1'b0;
    end
    if (start) begin
      if (state_q == ST_IDLE || (frame_end && !pvld_q)) begin
        // Empty slot at GAP exit: send the strobe straight away, back to back.
        launch = 1'b1;
      end else begin
        pa_d   = sample_a;
        pb_d   = sample_b;
        pvld_d = 1'b1;
        if (pvld_q && !frame_end) ovr_d = 1'b1;
      end
    end
`else
    if (start) begin
      if (state_q == ST_IDLE) launch = 1'b1;
      else                    ovr_d  = 1'b1;
    end
`endif

    if (launch) begin
      state_d = ST_SETUP;
      hcnt_d  = 8'd0;
      hp_d    = 6'd0;
      sha_d   = word_a;
      shb_d   = word_b;
      dina_d  = word_a[15];
      dinb_d  = word_b[15];
      sync_d  = 1'b0;
      sclk_d  = 1'b1;
      busy_d  = 1'b1;
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      hcnt_q  <= 8'd0;
      hp_q    <= 6'd0;
      sha_q   <= 16'd0;
      shb_q   <= 16'd0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      dina_q  <= 1'b0;
      dinb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      hp_q    <= hp_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      dina_q  <= dina_d;
      dinb_q  <= dinb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef DAC_TX_PENDING_EN
  // Pending slot registers; reset empties the slot.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      pvld_q <= 1'b0;
      pa_q   <= 12'd0;
      pb_q   <= 12'd0;
    end else begin
      pvld_q <= pvld_d;
      pa_q   <= pa_d;
      pb_q   <= pb_d;
    end
  end
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = ovr_q;
  assign dac_sync = sync_q;
  assign dac_sclk = sclk_q;
  assign dac_dina = dina_q;
  assign dac_dinb = dinb_q;

endmodule

// File: tb/tb_dac_da2_tx.sv
// tb_dac_da2_tx: scoreboard bench for dac_da2_tx at SCLK_DIV=1.
// The stimulus side runs a frame-level model and queues the expected words
// and done times. A negedge monitor decodes the serial lanes and checks them.
module tb_dac_da2_tx;
  localparam int DIV      = 1;
  localparam int H        = DIV + 1;
  localparam int FRAME    = 35 * H;
  localparam int SYNC_LOW = 33 * H;

  logic        CLOCK = 1'b0;
  logic        RESETN = 1'b0;
  logic        start = 1'b0;
  logic [11:0] sample_a = 12'd0;
  logic [11:0] sample_b = 12'd0;
  logic        busy, done, overrun, dac_sync, dac_sclk, dac_dina, dac_dinb;

  dac_da2_tx #(.SCLK_DIV(DIV)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN), .start(start),
    .sample_a(sample_a), .sample_b(sample_b),
    .busy(busy), .done(done), .overrun(overrun),
    .dac_sync(dac_sync), .dac_sclk(dac_sclk),
    .dac_dina(dac_dina), .dac_dinb(dac_dinb)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  int          exp_done_q[$];
  int last_end = -1000;   // edge on which the last scheduled frame ends
  int tent_e0  = -1;      // start edge of the not-yet-started pending frame
  int ovr_exp  = 0;
  int ovr_seen = 0;
  bit abort_f  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: start at edge c with codes a/b.
  task automatic model_start(input int c, input logic [11:0] a, input logic [11:0] b);
    if (c > last_end) begin
      exp_a_q.push_back({4'h0, a});
      exp_b_q.push_back({4'h0, b});
      exp_done_q.push_back(c + FRAME);
      last_end = c + FRAME;
      tent_e0  = -1;
    end else begin
`ifdef DAC_TX_PENDING_EN
      if (c < tent_e0) begin
        void'(exp_a_q.pop_back());
        void'(exp_b_q.pop_back());
        void'(exp_done_q.pop_back());
        exp_a_q.push_back({4'h0, a});
        exp_b_q.push_back({4'h0, b});
        exp_done_q.push_back(tent_e0 + FRAME);
        ovr_exp++;
      end else begin
        exp_a_q.push_back({4'h0, a});
        exp_b_q.push_back({4'h0, b});
        tent_e0 = last_end;
        exp_done_q.push_back(last_end + FRAME);
        last_end = last_end + FRAME;
      end
`else
      ovr_exp++;
`endif
    end
  endtask

  // Called just after a posedge; the strobe is sampled on the next edge.
  task automatic do_start(input logic [11:0] a, input logic [11:0] b);
    sample_a = a;
    sample_b = b;
    start    = 1'b1;
    model_start(cyc + 1, a, b);
    @(posedge CLOCK); #1;
    start    = 1'b0;
    sample_a = 12'($urandom);
    sample_b = 12'($urandom);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge CLOCK); #1; end
  endtask

  task automatic do_reset(input int n);
    abort_f = 1'b1;
    RESETN  = 1'b0;
    repeat (n) begin
      @(posedge CLOCK); #1;
      check("reset_idle", {dac_sync, dac_sclk, dac_dina, dac_dinb, busy, done, overrun}, 7'b1100000);
    end
    RESETN = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
    exp_done_q.delete();
    last_end = -1000;
    tent_e0  = -1;
  endtask

  task automatic settle();
    int k = 0;
    while ((exp_done_q.size() != 0 || busy) && k < 2000) begin
      @(posedge CLOCK); #1;
      k++;
    end
    wait_cyc(FRAME + 10);
    check("drain_done", exp_done_q.size(), 0);
    check("drain_words", exp_a_q.size(), 0);
    check("overrun_count", ovr_seen, ovr_exp);
  endtask

  // Monitor: decode lanes at SCLK falls, time SYNC-low and done pulses.
  initial begin
    int bitcnt = 0;
    int synclow = 0;
    logic [15:0] cap_a = 16'd0;
    logic [15:0] cap_b = 16'd0;
    logic prev_sclk = 1'b1;
    forever begin
      @(negedge CLOCK);
      if (dac_sync) begin
        if (synclow > 0 && !abort_f) check("sync_low_len", synclow, SYNC_LOW);
        synclow = 0;
        bitcnt  = 0;
        abort_f = 1'b0;
      end else begin
        synclow++;
        if (prev_sclk && !dac_sclk) begin
          cap_a = {cap_a[14:0], dac_dina};
          cap_b = {cap_b[14:0], dac_dinb};
          bitcnt++;
          if (bitcnt == 16) begin
            if (exp_a_q.size() == 0) check("word_unexpected", exp_a_q.size(), 1);
            else begin
              check("lane_a", cap_a, exp_a_q.pop_front());
              check("lane_b", cap_b, exp_b_q.pop_front());
            end
          end
        end
      end
      prev_sclk = dac_sclk;
      if (done) begin
        if (exp_done_q.size() == 0) check("done_unexpected", exp_done_q.size(), 1);
        else check("done_time", cyc, exp_done_q.pop_front());
      end
      if (overrun) ovr_seen++;
    end
  end

  initial begin
    wait_cyc(1);
    do_reset(3);
    wait_cyc(3);

    // Single frame.
    do_start(12'hA5C, 12'h3F0);
    settle();

    // Second strobe mid-frame: pending back to back, or dropped.
    do_start(12'h5A5, 12'hC3C);
    wait_cyc(19);
    do_start(12'hFFF, 12'h001);
    settle();

    // Two mid-frame strobes: second overwrites the first.
    do_start(12'h777, 12'h888);
    wait_cyc(9);
    do_start(12'h111, 12'h0AA);
    wait_cyc(9);
    do_start(12'h222, 12'h0BB);
    settle();

    // One-cycle reset on the 5th SCLK fall, then a fresh frame.
    do_start(12'hABC, 12'hDEF);
    wait_cyc(17);
    do_reset(1);
    wait_cyc(4);
    do_start(12'h123, 12'h456);
    settle();

    // Three-cycle reset mid-stream, then a fresh frame.
    do_start(12'h9E1, 12'h1E9);
    wait_cyc(40);
    do_reset(3);
    wait_cyc(2);
    do_start(12'h800, 12'h7FF);
    settle();

    // Randomized strobes, some landing mid-frame.
    for (int i = 0; i < 24; i++) begin
      do_start(12'($urandom), 12'($urandom));
      wait_cyc($urandom_range(5, 100));
    end
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
